// File: rtl/seg7_hex_reader.sv
// Recovers hex nibbles from a multiplexed 7-segment display bus: debounces the bus,
// decodes each stable segment pattern and stores it against the enabled digit.
module seg7_hex_reader #(
  parameter int NUM_DIGITS     = 4,
  parameter int STABLE_CYCLES  = 3,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [4*NUM_DIGITS-1:0] hex_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    upd_pulse,
  output logic [2:0]              upd_idx,
  output logic                    sel_err
);

  localparam int SW = NUM_DIGITS + 7;
  localparam logic [7:0] CNT_MAX    = 8'(STABLE_CYCLES);
  localparam logic [7:0] CNT_COMMIT = 8'(STABLE_CYCLES - 1);

  typedef enum logic {
    TRACK = 1'b0,
    HOLD  = 1'b1
  } state_t;

  logic [SW-1:0]           smp_q, smp_d;
  logic [7:0]              cnt_q, cnt_d;
  state_t                  state_q, state_d;
  logic [4*NUM_DIGITS-1:0] hex_q, hex_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic [NUM_DIGITS-1:0]   err_q, err_d;
  logic                    upd_pulse_q, upd_pulse_d;
  logic [2:0]              upd_idx_q, upd_idx_d;
  logic                    sel_err_q, sel_err_d;

  logic [6:0]            seg_fix;
  logic                  same;
  logic                  commit;
  logic                  one_hot;
  logic [NUM_DIGITS-1:0] smp_dig;
  logic [6:0]            smp_seg;
  logic [4:0]            dec;

  // Returns {known, nibble}; known=0 for any pattern outside the 16 glyphs.
  function automatic logic [4:0] decode(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'h3F:   r = {1'b1, 4'h0};
      7'h06:   r = {1'b1, 4'h1};
      7'h5B:   r = {1'b1, 4'h2};
      7'h4F:   r = {1'b1, 4'h3};
      7'h66:   r = {1'b1, 4'h4};
      7'h6D:   r = {1'b1, 4'h5};
      7'h7D:   r = {1'b1, 4'h6};
      7'h07:   r = {1'b1, 4'h7};
      7'h7F:   r = {1'b1, 4'h8};
      7'h6F:   r = {1'b1, 4'h9};
      7'h77:   r = {1'b1, 4'hA};
      7'h7C:   r = {1'b1, 4'hB};
      7'h39:   r = {1'b1, 4'hC};
      7'h5E:   r = {1'b1, 4'hD};
      7'h79:   r = {1'b1, 4'hE};
      7'h71:   r = {1'b1, 4'hF};
      default: r = 5'b0_0000;
    endcase
    return r;
  endfunction

  always_comb begin
    seg_fix = (SEG_ACTIVE_LOW != 0) ? ~seg_in : seg_in;
    smp_d   = {dig_sel, seg_fix};
    same    = (smp_d == smp_q);
    cnt_d   = same ? ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + 8'd1) : 8'd0;
    commit  = (state_q == TRACK) && (cnt_q == CNT_COMMIT);

    smp_dig = smp_q[SW-1:7];
    smp_seg = smp_q[6:0];
    dec     = decode(smp_seg);
    one_hot = (smp_dig != '0) && ((smp_dig & (smp_dig - 1'b1)) == '0);

    // A commit that coincides with a bus change stays in TRACK so the new value gets its own window.
    state_d = state_q;
    case (state_q)
      TRACK:   if (commit && same) state_d = HOLD;
      HOLD:    if (!same) state_d = TRACK;
      default: state_d = TRACK;
    endcase

    hex_d       = hex_q;
    valid_d     = valid_q;
    err_d       = err_q;
    upd_pulse_d = 1'b0;
    upd_idx_d   = upd_idx_q;
    sel_err_d   = 1'b0;

    if (commit) begin
      if (one_hot) begin
        upd_pulse_d = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (smp_dig[i]) begin
            upd_idx_d = 3'(i);
            if (dec[4]) begin
              hex_d[4*i +: 4] = dec[3:0];
              valid_d[i]      = 1'b1;
              err_d[i]        = 1'b0;
            end else begin
              err_d[i] = 1'b1;
            end
          end
        end
      end else if (smp_dig != '0) begin
        sel_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smp_q       <= '0;
      cnt_q       <= '0;
      state_q     <= TRACK;
      hex_q       <= '0;
      valid_q     <= '0;
      err_q       <= '0;
      upd_pulse_q <= 1'b0;
      upd_idx_q   <= 3'd0;
      sel_err_q   <= 1'b0;
    end else begin
      smp_q       <= smp_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      hex_q       <= hex_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      upd_pulse_q <= upd_pulse_d;
      upd_idx_q   <= upd_idx_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign hex_out     = hex_q;
  assign digit_valid = valid_q;
  assign digit_err   = err_q;
  assign upd_pulse   = upd_pulse_q;
  assign upd_idx     = upd_idx_q;
  assign sel_err     = sel_err_q;

endmodule
